// File: rtl/rv_axil_pkg.sv
// Shared types and AXI4-Lite constants for the rv32 core to AXI4-Lite bridge.
package rv_axil_pkg;

    typedef logic [31:0] u32_t;
    typedef logic [3:0]  u4_t;

    typedef enum logic [2:0] {
        StIdle,
        StWreq,
        StWresp,
        StRreq,
        StRdata,
        StDone
    } axil_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/rv_axil_bridge.sv
// Turns single core data-bus accesses inside [BASE, BASE + 2**AW_WIN) into AXI4-Lite transfers.
// Optional first-error capture (err/err_adr/err_clr) is built when RV_AXIL_ERR_CAPTURE_EN is defined.
module rv_axil_bridge
    import rv_axil_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'hC000_0000,
    parameter int unsigned AW_WIN = 24
) (
    input  logic        cclk,
    input  logic        reset,
    input  u32_t        adr,
    input  u4_t         we,
    input  logic        re,
    input  u32_t        dw,
    output u32_t        dr,
    output logic        rdy,
    output u32_t        m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output u32_t        m_wdata,
    output u4_t         m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output u32_t        m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  u32_t        m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
`ifdef RV_AXIL_ERR_CAPTURE_EN
    output logic        err,
    output u32_t        err_adr,
    input  logic        err_clr,
`endif
    output logic        m_rready
);

    axil_state_t state_q, state_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic arvalid_q, arvalid_d, rready_q, rready_d;
    logic rd_done_q, rd_done_d, dr_en_q, dr_en_d;
    u32_t addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    u4_t  wstrb_q, wstrb_d;
    logic sel, wreq, rreq;

    assign sel  = (adr[31:AW_WIN] == BASE[31:AW_WIN]);
    assign wreq = sel && (we != 4'b0000);
    assign rreq = sel && re && (we == 4'b0000);

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rd_done_d = 1'b0;
        // Read data appears on dr the cycle after DONE, like rv_mem's registered read.
        dr_en_d   = rd_done_q;
        rdy       = 1'b0;
        unique case (state_q)
            StIdle: begin
                rdy = !wreq && !rreq;
                if (wreq) begin
                    addr_d    = {adr[31:2], 2'b00};
                    wdata_d   = dw;
                    wstrb_d   = we;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWreq;
                end else if (rreq) begin
                    addr_d    = {adr[31:2], 2'b00};
                    arvalid_d = 1'b1;
                    state_d   = StRreq;
                end
            end
            StWreq: begin
                // AW and W retire independently; move on once both have handshaken.
                awvalid_d = awvalid_q && !m_awready;
                wvalid_d  = wvalid_q && !m_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (m_bvalid) begin
                    bready_d = 1'b0;
                    state_d  = StDone;
                end
            end
            StRreq: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (m_rvalid) begin
                    rdata_d   = m_rdata;
                    rready_d  = 1'b0;
                    rd_done_d = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                rdy     = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rd_done_q <= 1'b0;
            dr_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rd_done_q <= rd_done_d;
            dr_en_q   <= dr_en_d;
        end
    end

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_awvalid = awvalid_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign dr        = dr_en_q ? rdata_q : '0;

`ifdef RV_AXIL_ERR_CAPTURE_EN
    logic err_q, err_d, new_err;
    u32_t err_adr_q, err_adr_d;

    assign new_err = (state_q == StWresp && m_bvalid && m_bresp[1]) ||
                     (state_q == StRdata && m_rvalid && m_rresp[1]);

    always_comb begin
        err_d     = err_q;
        err_adr_d = err_adr_q;
        if (err_clr) begin
            err_d = 1'b0;
        end else if (!err_q && new_err) begin
            err_d     = 1'b1;
            err_adr_d = addr_q;
        end
    end

    always_ff @(posedge cclk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign err     = err_q;
    assign err_adr = err_adr_q;

    logic unused_adr;
    assign unused_adr = ^adr[1:0];
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp, adr[1:0]};
`endif

endmodule

// File: tb/tb_rv_axil_bridge.sv
// Directed bench for rv_axil_bridge with a small configurable-latency AXI4-Lite slave.
// Define RV_AXIL_ERR_CAPTURE_EN to also exercise the error-capture ports.
module tb_rv_axil_bridge;

    logic        cclk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] adr = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic [31:0] dw = '0;
    logic [31:0] dr;
    logic        rdy;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
`ifdef RV_AXIL_ERR_CAPTURE_EN
    logic        err;
    logic [31:0] err_adr;
    logic        err_clr = 1'b0;
`endif

    rv_axil_bridge dut (
        .cclk      (cclk),
        .reset     (reset),
        .adr       (adr),
        .we        (we),
        .re        (re),
        .dw        (dw),
        .dr        (dr),
        .rdy       (rdy),
        .m_awaddr  (m_awaddr),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
`ifdef RV_AXIL_ERR_CAPTURE_EN
        .err       (err),
        .err_adr   (err_adr),
        .err_clr   (err_clr),
`endif
        .m_rready  (m_rready)
    );

    always #5 cclk = ~cclk;

    // Slave configuration
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    // Slave state and monitors
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic        aw_done = 1'b0, w_done = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    int          cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, bready_ph = 0, busy_cyc = 0, viol = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        prev_bready = 1'b0;
    logic        prev_awv = 1'b0, prev_awhs = 1'b0, prev_wv = 1'b0, prev_whs = 1'b0;
    logic        prev_arv = 1'b0, prev_arhs = 1'b0;

    assign m_awready = m_awvalid && (aw_cnt >= aw_delay);
    assign m_wready  = m_wvalid && (w_cnt >= w_delay);
    assign m_arready = m_arvalid && (ar_cnt >= ar_delay);
    assign m_bvalid  = b_pend;
    assign m_bresp   = bresp_cfg;
    assign m_rvalid  = r_pend && (r_cnt >= r_delay);
    assign m_rdata   = rdata_cfg;
    assign m_rresp   = rresp_cfg;

    always @(posedge cclk) begin
        logic a_now, w_now;
        cyc <= cyc + 1;
        if (reset) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            prev_bready <= 1'b0; prev_awv <= 1'b0; prev_wv <= 1'b0; prev_arv <= 1'b0;
            prev_awhs <= 1'b0; prev_whs <= 1'b0; prev_arhs <= 1'b0;
        end else begin
            if (m_awvalid && m_awready) begin
                aw_cnt <= 0; aw_hs_n <= aw_hs_n + 1; cap_awaddr <= m_awaddr; aw_hs_cyc <= cyc;
            end else if (m_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_wvalid && m_wready) begin
                w_cnt <= 0; w_hs_n <= w_hs_n + 1; cap_wdata <= m_wdata; cap_wstrb <= m_wstrb;
                w_hs_cyc <= cyc;
            end else if (m_wvalid) w_cnt <= w_cnt + 1;
            a_now = aw_done || (m_awvalid && m_awready);
            w_now = w_done || (m_wvalid && m_wready);
            if (a_now && w_now) begin
                b_pend <= 1'b1; aw_done <= 1'b0; w_done <= 1'b0;
            end else begin
                aw_done <= a_now; w_done <= w_now;
            end
            if (m_bvalid && m_bready) begin
                b_pend <= 1'b0; b_hs_n <= b_hs_n + 1;
            end
            if (m_arvalid && m_arready) begin
                ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1; cap_araddr <= m_araddr;
                r_pend <= 1'b1; r_cnt <= 0;
            end else if (m_arvalid) ar_cnt <= ar_cnt + 1;
            if (m_rvalid && m_rready) begin
                r_pend <= 1'b0; r_hs_n <= r_hs_n + 1;
            end else if (r_pend) r_cnt <= r_cnt + 1;
            if (m_bready && !prev_bready) bready_ph <= bready_ph + 1;
            prev_bready <= m_bready;
            if (m_awvalid || m_wvalid || m_arvalid || m_bready || m_rready) busy_cyc <= busy_cyc + 1;
            if ((prev_awv && !prev_awhs && !m_awvalid) || (prev_wv && !prev_whs && !m_wvalid) ||
                (prev_arv && !prev_arhs && !m_arvalid)) viol <= viol + 1;
            prev_awv <= m_awvalid; prev_awhs <= m_awvalid && m_awready;
            prev_wv <= m_wvalid;   prev_whs <= m_wvalid && m_wready;
            prev_arv <= m_arvalid; prev_arhs <= m_arvalid && m_arready;
        end
    end

    int n_checks = 0, n_pass = 0;
    int r_stall, r_drnz;
    logic [31:0] r_dr_after, r_dr_later;

    // Issue one core access and hold it until rdy, then drop it and sample dr twice.
    task automatic run_req(input logic [31:0] a, input logic [3:0] w, input logic r,
                           input logic [31:0] d);
        @(posedge cclk); #1;
        adr = a; we = w; re = r; dw = d;
        r_stall = 0; r_drnz = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge cclk);
            if (dr !== 32'h0) r_drnz++;
            if (rdy === 1'b1) break;
            r_stall++;
        end
        @(posedge cclk); #1;
        adr = '0; we = '0; re = 1'b0; dw = '0;
        @(negedge cclk); r_dr_after = dr;
        @(negedge cclk); r_dr_later = dr;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge cclk);
        #1 reset = 1'b0;
        @(negedge cclk);
        n_checks++; if (rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", rdy); else n_pass++;
        n_checks++; if (dr !== 32'h0) $display("FAIL reset_dr: got %h want 0", dr); else n_pass++;
        n_checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0)
            $display("FAIL reset_handshake: got %b want 00000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        else n_pass++;
        n_checks++; if (m_awaddr !== 32'h0) $display("FAIL reset_addr: got %h want 0", m_awaddr);
        else n_pass++;
`ifdef RV_AXIL_ERR_CAPTURE_EN
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
`endif
    endtask

    task automatic test_write_zero_wait();
        int aw0 = aw_hs_n, w0 = w_hs_n, b0 = b_hs_n;
        aw_delay = 0; w_delay = 0;
        run_req(32'hC000_0012, 4'b1100, 1'b0, 32'h1234_5678);
        n_checks++; if (r_stall !== 3) $display("FAIL wr_stall: got %0d want 3", r_stall); else n_pass++;
        n_checks++; if (cap_awaddr !== 32'hC000_0010)
            $display("FAIL wr_awaddr: got %h want c0000010", cap_awaddr); else n_pass++;
        n_checks++; if (cap_wstrb !== 4'b1100)
            $display("FAIL wr_wstrb: got %b want 1100", cap_wstrb); else n_pass++;
        n_checks++; if (cap_wdata !== 32'h1234_5678)
            $display("FAIL wr_wdata: got %h want 12345678", cap_wdata); else n_pass++;
        n_checks++; if ((aw_hs_n - aw0) != 1 || (w_hs_n - w0) != 1 || (b_hs_n - b0) != 1)
            $display("FAIL wr_counts: got aw%0d w%0d b%0d want 1 each",
                     aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0);
        else n_pass++;
        n_checks++; if (r_drnz != 0 || r_dr_after !== 32'h0)
            $display("FAIL wr_dr: got nz%0d after %h want 0/0", r_drnz, r_dr_after); else n_pass++;
    endtask

    task automatic test_read_delayed();
        int ar0 = ar_hs_n, r0 = r_hs_n;
        ar_delay = 3; r_delay = 2; rdata_cfg = 32'hA5A5_0001;
        run_req(32'hC000_0020, 4'b0000, 1'b1, 32'h0);
        n_checks++; if (r_stall !== 8) $display("FAIL rd_stall: got %0d want 8", r_stall); else n_pass++;
        n_checks++; if (cap_araddr !== 32'hC000_0020)
            $display("FAIL rd_araddr: got %h want c0000020", cap_araddr); else n_pass++;
        n_checks++; if ((ar_hs_n - ar0) != 1 || (r_hs_n - r0) != 1)
            $display("FAIL rd_counts: got ar%0d r%0d want 1 each", ar_hs_n - ar0, r_hs_n - r0);
        else n_pass++;
        n_checks++; if (r_drnz != 0) $display("FAIL rd_dr_early: got %0d nonzero want 0", r_drnz);
        else n_pass++;
        n_checks++; if (r_dr_after !== 32'hA5A5_0001)
            $display("FAIL rd_dr_after: got %h want a5a50001", r_dr_after); else n_pass++;
        n_checks++; if (r_dr_later !== 32'h0)
            $display("FAIL rd_dr_later: got %h want 0", r_dr_later); else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL rd_valid_drop: got %0d want 0", viol); else n_pass++;
        ar_delay = 0; r_delay = 0;
    endtask

    task automatic test_unselected();
        int busy0 = busy_cyc;
        rdata_cfg = 32'hFFFF_FFFF;
        run_req(32'h0000_1000, 4'b0000, 1'b1, 32'h0);
        n_checks++; if (r_stall !== 0) $display("FAIL unsel_stall: got %0d want 0", r_stall);
        else n_pass++;
        n_checks++; if (busy_cyc != busy0)
            $display("FAIL unsel_axi: got %0d busy cycles want 0", busy_cyc - busy0); else n_pass++;
        n_checks++; if (r_drnz != 0 || r_dr_after !== 32'h0)
            $display("FAIL unsel_dr: got nz%0d after %h want 0/0", r_drnz, r_dr_after);
        else n_pass++;
    endtask

    task automatic test_write_split();
        int b0 = b_hs_n, ph0 = bready_ph;
        aw_delay = 1; w_delay = 3;
        run_req(32'hC000_0104, 4'b0011, 1'b0, 32'hDEAD_BEEF);
        n_checks++; if (r_stall !== 6) $display("FAIL split_stall: got %0d want 6", r_stall);
        else n_pass++;
        n_checks++; if ((w_hs_cyc - aw_hs_cyc) != 2)
            $display("FAIL split_order: got %0d want 2", w_hs_cyc - aw_hs_cyc); else n_pass++;
        n_checks++; if ((bready_ph - ph0) != 1 || (b_hs_n - b0) != 1)
            $display("FAIL split_b: got ph%0d b%0d want 1/1", bready_ph - ph0, b_hs_n - b0);
        else n_pass++;
        n_checks++; if (cap_wdata !== 32'hDEAD_BEEF || cap_wstrb !== 4'b0011)
            $display("FAIL split_w: got %h/%b want deadbeef/0011", cap_wdata, cap_wstrb);
        else n_pass++;
        n_checks++; if (viol != 0) $display("FAIL split_valid_drop: got %0d want 0", viol);
        else n_pass++;
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_reset_mid_read();
        bit seen = 1'b0;
        r_delay = 10; rdata_cfg = 32'h1111_2222;
        @(posedge cclk); #1;
        adr = 32'hC000_0100; re = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge cclk);
            if (m_rready === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) $display("FAIL mid_rdata_reach: got 0 want 1"); else n_pass++;
        reset = 1'b1; re = 1'b0; adr = '0;
        @(negedge cclk);
        n_checks++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0)
            $display("FAIL mid_handshake: got %b want 00000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        else n_pass++;
        n_checks++; if (rdy !== 1'b1 || dr !== 32'h0)
            $display("FAIL mid_rdy_dr: got %b/%h want 1/0", rdy, dr); else n_pass++;
        @(posedge cclk); #1 reset = 1'b0;
        r_delay = 0; rdata_cfg = 32'h3C3C_0005;
        run_req(32'hC000_0104, 4'b0000, 1'b1, 32'h0);
        n_checks++; if (r_stall !== 3) $display("FAIL mid_next_stall: got %0d want 3", r_stall);
        else n_pass++;
        n_checks++; if (r_dr_after !== 32'h3C3C_0005)
            $display("FAIL mid_next_dr: got %h want 3c3c0005", r_dr_after); else n_pass++;
    endtask

`ifdef RV_AXIL_ERR_CAPTURE_EN
    task automatic test_err_capture();
        bresp_cfg = 2'b10;
        run_req(32'hC000_0044, 4'b1111, 1'b0, 32'h0000_00AA);
        bresp_cfg = 2'b00; rresp_cfg = 2'b11;
        run_req(32'hC000_0048, 4'b0000, 1'b1, 32'h0);
        rresp_cfg = 2'b00;
        n_checks++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else n_pass++;
        n_checks++; if (err_adr !== 32'hC000_0044)
            $display("FAIL err_adr: got %h want c0000044", err_adr); else n_pass++;
        @(posedge cclk); #1 err_clr = 1'b1;
        @(posedge cclk); #1 err_clr = 1'b0;
        @(negedge cclk);
        n_checks++; if (err !== 1'b0) $display("FAIL err_clr: got %b want 0", err); else n_pass++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_delayed();
        test_unselected();
        test_write_split();
        test_reset_mid_read();
`ifdef RV_AXIL_ERR_CAPTURE_EN
        test_err_capture();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
